// File: rtl/spi_inemo4_if.sv
// spi_inemo4_if
//   SPI bus plus the data-ready interrupt between a host and the iNEMO gyro model.
//   Signals:
//     SS_n  - active-low slave select (host -> gyro)
//     SCLK  - SPI clock, idles low (host -> gyro)
//     MOSI  - serial data host -> gyro
//     MISO  - serial data gyro -> host
//     INT   - new-sample-ready flag (gyro -> host)
//   Modports: master (host side), slave (gyro side).
interface spi_inemo4_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/spi_inemo4.sv
// spi_inemo4
//   Synthesizable iNEMO gyro model acting as an SPI slave (mode 0, 16-bit frames).
//   The SPI lines are oversampled with clk; no logic runs on SCLK edges.
//   A yaw-rate sample is latched every ODR_PERIOD clocks while both INT enable
//   (INT1_CTRL[1]) and gyro enable (CTRL2_G != 0) are set, and INT is raised.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset
//     YAW  - signed 16-bit yaw rate from the physics model
//     bus  - spi_inemo4_if.slave (SS_n, SCLK, MOSI in; MISO, INT out)
//   Parameters:
//     ODR_PERIOD   - clocks between samples
//     WHO_AM_I_VAL - value returned at address 0x0F
//   Optional feature macro: STATUS_REG_EN
//     defined   -> address 0x1E reads {6'b0, GDA(=INT), 1'b0}
//     undefined -> address 0x1E reads 0x00
module spi_inemo4 #(
  parameter int          ODR_PERIOD   = 16384,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    YAW,
  spi_inemo4_if.slave    bus
);

  localparam int             CW       = (ODR_PERIOD > 1) ? $clog2(ODR_PERIOD) : 1;
  localparam logic [CW-1:0]  ODR_LAST = CW'(ODR_PERIOD - 1);

  // [0],[1] form the 2-flop synchronizer; [2] is the previous synchronized
  // value used for edge detection.
  logic [2:0]  ss_sync_reg;
  logic [2:0]  sclk_sync_reg;
  logic [1:0]  mosi_sync_reg;

  logic        ss_s, mosi_s;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [4:0]  bit_cnt_reg;
  logic [15:0] shift_in_reg;
  logic [15:0] shift_in_next;
  logic [7:0]  shift_out_reg;
  logic        miso_reg;
  logic [7:0]  rd_byte;

  logic [7:0]  int1_ctrl_reg;
  logic [7:0]  ctrl2_reg;
  logic [15:0] yaw_out_reg;
  logic        int_reg;
  logic        sample_pend_reg;
  logic [CW-1:0] odr_cnt_reg;

  logic        frame_done;
  logic        sampling_en;
  logic        odr_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_reg   <= 3'b111;
      sclk_sync_reg <= 3'b000;
      mosi_sync_reg <= 2'b00;
    end else begin
      ss_sync_reg   <= {ss_sync_reg[1:0], bus.SS_n};
      sclk_sync_reg <= {sclk_sync_reg[1:0], bus.SCLK};
      mosi_sync_reg <= {mosi_sync_reg[0], bus.MOSI};
    end
  end

  assign ss_s      = ss_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  assign ss_fall   =  ss_sync_reg[2] & ~ss_sync_reg[1];
  assign ss_rise   = ~ss_sync_reg[2] &  ss_sync_reg[1];
  assign sclk_rise = ~sclk_sync_reg[2] &  sclk_sync_reg[1];
  assign sclk_fall =  sclk_sync_reg[2] & ~sclk_sync_reg[1];

  assign shift_in_next = {shift_in_reg[14:0], mosi_s};

  // Register read mux, addressed by the command byte as it completes on the
  // 8th rise (shift_in_next[7] = R/W, shift_in_next[6:0] = address).
  always_comb begin
    rd_byte = 8'h00;
    case (shift_in_next[6:0])
      7'h0F:   rd_byte = WHO_AM_I_VAL;
      7'h0D:   rd_byte = int1_ctrl_reg;
      7'h11:   rd_byte = ctrl2_reg;
      7'h26:   rd_byte = yaw_out_reg[7:0];
      7'h27:   rd_byte = yaw_out_reg[15:8];
`ifdef STATUS_REG_EN
      7'h1E:   rd_byte = {6'b000000, int_reg, 1'b0};
`endif
      default: rd_byte = 8'h00;
    endcase
  end

  // Serial engine. The counter saturates at 17 so that any over-long frame
  // can never alias back to a count of 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg   <= 5'd0;
      shift_in_reg  <= 16'h0000;
      shift_out_reg <= 8'h00;
      miso_reg      <= 1'b0;
    end else if (ss_fall) begin
      bit_cnt_reg   <= 5'd0;
      shift_in_reg  <= 16'h0000;
      shift_out_reg <= 8'h00;
      miso_reg      <= 1'b0;
    end else if (ss_s) begin
      shift_out_reg <= 8'h00;
      miso_reg      <= 1'b0;
    end else if (sclk_rise) begin
      shift_in_reg <= shift_in_next;
      if (bit_cnt_reg != 5'd17)
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
      if (bit_cnt_reg == 5'd7 && shift_in_next[7])
        shift_out_reg <= rd_byte;
    end else if (sclk_fall) begin
      miso_reg      <= shift_out_reg[7];
      shift_out_reg <= {shift_out_reg[6:0], 1'b0};
    end
  end

  // ss_rise is detected while bit_cnt_reg/shift_in_reg still hold the frame.
  assign frame_done  = ss_rise && (bit_cnt_reg == 5'd16);
  assign sampling_en = int1_ctrl_reg[1] && (ctrl2_reg != 8'h00);
  assign odr_wrap    = sampling_en && (odr_cnt_reg == ODR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_ctrl_reg   <= 8'h00;
      ctrl2_reg       <= 8'h00;
      yaw_out_reg     <= 16'h0000;
      int_reg         <= 1'b0;
      sample_pend_reg <= 1'b0;
      odr_cnt_reg     <= '0;
    end else begin
      if (frame_done && !shift_in_reg[15]) begin
        case (shift_in_reg[14:8])
          7'h0D:   int1_ctrl_reg <= shift_in_reg[7:0];
          7'h11:   ctrl2_reg     <= shift_in_reg[7:0];
          default: ;
        endcase
      end

      if (!sampling_en || odr_wrap)
        odr_cnt_reg <= '0;
      else
        odr_cnt_reg <= odr_cnt_reg + 1'b1;

      if (!int1_ctrl_reg[1]) begin
        int_reg         <= 1'b0;
        sample_pend_reg <= 1'b0;
      end else begin
        if (frame_done && shift_in_reg[15] && shift_in_reg[14:8] == 7'h27)
          int_reg <= 1'b0;
        // The copy waits while SS_n is low so OUTZ_L/OUTZ_H of one frame
        // always come from the same sample. Placed after the clear so that
        // a sample landing on the clear cycle leaves INT set.
        if (sample_pend_reg && ss_s) begin
          yaw_out_reg     <= YAW;
          int_reg         <= 1'b1;
          sample_pend_reg <= 1'b0;
        end
        if (odr_wrap)
          sample_pend_reg <= 1'b1;
      end
    end
  end

  assign bus.MISO = miso_reg;
  assign bus.INT  = int_reg;

endmodule

// File: tb/tb_spi_inemo4.sv
// tb_spi_inemo4
//   Self-checking bench for spi_inemo4. A register-level model (register
//   values, latched sample, INT flag) predicts every read; random frames,
//   aborted frames and directed sample/INT scenarios exercise the design.
module tb_spi_inemo4;

  localparam int ODR = 2048;
  localparam logic [7:0] WHO = 8'h6A;

  logic        clk;
  logic        rst;
  logic [15:0] YAW;
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          t_int;

  // reference model state
  logic [7:0]  m_int1;
  logic [7:0]  m_ctrl2;
  logic [15:0] m_yaw;
  logic        m_int;

  spi_inemo4_if bus ();

  spi_inemo4 #(.ODR_PERIOD(ODR), .WHO_AM_I_VAL(WHO)) dut (
    .clk (clk),
    .rst (rst),
    .YAW (YAW),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h0F:   return WHO;
      7'h0D:   return m_int1;
      7'h11:   return m_ctrl2;
      7'h26:   return m_yaw[7:0];
      7'h27:   return m_yaw[15:8];
`ifdef STATUS_REG_EN
      7'h1E:   return {6'b000000, m_int, 1'b0};
`endif
      default: return 8'h00;
    endcase
  endfunction

  // One SS_n-low window of nbits SCLK periods (16 clk each). MISO is sampled
  // just before each rise; int_pre is INT just before SS_n is released.
  task automatic spi_frame(input logic [15:0] word, input int nbits,
                           output logic [7:0] rd, output logic [7:0] cmd_miso,
                           output logic int_pre);
    rd = 8'h00;
    cmd_miso = 8'h00;
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = (i < 16) ? word[15 - i] : 1'b0;
      repeat (8) @(negedge clk);
      if (i < 8) cmd_miso = {cmd_miso[6:0], bus.MISO};
      else if (i < 16) rd = {rd[6:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (8) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (8) @(negedge clk);
    int_pre = bus.INT;
    bus.SS_n = 1'b1;
    repeat (8) @(negedge clk);
    check("miso_idle", bus.MISO, 1'b0);
  endtask

  task automatic spi_read(input logic [6:0] a, input string tag, output logic int_pre);
    logic [7:0] rd, cm;
    spi_frame({1'b1, a, 8'h00}, 16, rd, cm, int_pre);
    check({tag, "_cmd"}, cm, 8'h00);
    check(tag, rd, model_read(a));
    if (a == 7'h27) m_int = 1'b0;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd, cm;
    logic ib;
    spi_frame({1'b0, a, d}, 16, rd, cm, ib);
    if (a == 7'h0D) m_int1 = d;
    else if (a == 7'h11) m_ctrl2 = d;
    $display("write %02h <= %02h", a, d);
  endtask

  task automatic wait_int(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.INT !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.INT, 1'b1);
    t_int = cyc;
  endtask

  initial begin
    logic        ib;
    logic [7:0]  rd, cm;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [6:0]  addr_tab [7];
    int          kind, nb;
    logic        seen;

    n_checks = 0;
    n_errors = 0;
    t_int    = 0;
    addr_tab = '{7'h0D, 7'h11, 7'h0F, 7'h26, 7'h27, 7'h1E, 7'h00};
    m_int1 = 8'h00; m_ctrl2 = 8'h00; m_yaw = 16'h0000; m_int = 1'b0;

    rst = 1'b1; YAW = 16'h0000;
    bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", bus.MISO, 1'b0);
    check("rst_int", bus.INT, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    spi_read(7'h0F, "rd_whoami", ib);
    check("int_after_rst", bus.INT, 1'b0);

    // Random frames with sampling kept disabled (INT1_CTRL[1] forced 0).
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 3);
      a = addr_tab[$urandom_range(0, 6)];
      if (a == 7'h00) a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      if (a == 7'h0D) d = d & 8'hFD;
      YAW = 16'($urandom);
      if (kind == 0) begin
        nb = $urandom_range(1, 16);
        if (nb == 16) nb = 17;
        spi_frame({1'($urandom), a, d}, nb, rd, cm, ib);
        $display("abort frame addr %02h bits %0d", a, nb);
      end else if (kind == 1) begin
        spi_write(a, d);
      end else begin
        spi_read(a, "rd_rand", ib);
      end
    end
    spi_read(7'h0D, "rd_rand_int1", ib);
    spi_read(7'h11, "rd_rand_ctrl2", ib);
    check("int_rand_quiet", bus.INT, 1'b0);

    // First sample.
    YAW = 16'hFC18;
    spi_write(7'h0D, 8'h02);
    spi_write(7'h11, 8'h60);
    wait_int(ODR + 12, "int_rise");
    m_yaw = 16'hFC18; m_int = 1'b1;
    spi_read(7'h26, "rd_outz_l", ib);
    check("int_hold_l", bus.INT, 1'b1);
    spi_read(7'h1E, "rd_status", ib);
    check("int_hold_status", bus.INT, 1'b1);
    spi_read(7'h27, "rd_outz_h", ib);
    check("int_before_clr", ib, 1'b1);
    check("int_clr", bus.INT, 1'b0);

    // Wrap lands inside a read of 0x26: copy deferred until SS_n rises.
    while (cyc < t_int + ODR - 150) @(negedge clk);
    YAW = 16'h1234;
    spi_read(7'h26, "rd_defer_l", ib);
    check("int_deferred", ib, 1'b0);
    check("int_after_defer", bus.INT, 1'b1);
    m_yaw = 16'h1234; m_int = 1'b1;
    spi_read(7'h26, "rd_new_l", ib);
    spi_read(7'h27, "rd_new_h", ib);
    check("int_clr2", bus.INT, 1'b0);

    // Aborted writes leave registers unchanged.
    spi_frame({1'b0, 7'h0D, 8'h00}, 10, rd, cm, ib);
    spi_read(7'h0D, "rd_abort10", ib);
    spi_frame({1'b0, 7'h11, 8'h00}, 17, rd, cm, ib);
    spi_read(7'h11, "rd_abort17", ib);

    // Clearing INT enable drops INT immediately; gyro off keeps INT quiet.
    wait_int(2 * ODR, "int_rise_b");
    m_int = 1'b1;
    spi_write(7'h0D, 8'h00);
    check("int_dis_clr", bus.INT, 1'b0);
    m_int = 1'b0;
    spi_write(7'h11, 8'h00);
    spi_write(7'h0D, 8'h02);
    seen = 1'b0;
    repeat (3 * ODR) begin
      @(negedge clk);
      if (bus.INT === 1'b1) seen = 1'b1;
    end
    check("int_quiet_gyro_off", seen, 1'b0);
    spi_read(7'h27, "rd_h_idle", ib);

    // Reset in the middle of a read of WHO_AM_I.
    spi_write(7'h11, 8'h60);
    wait_int(ODR + 12, "int_rise_c");
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.MOSI = (i == 0) ? 1'b1 : ((i >= 4 && i <= 7) ? 1'b1 : 1'b0); // 0x8F..
      repeat (8) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (8) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (8) @(negedge clk);
    check("miso_pre_rst", bus.MISO, 1'b1);
    rst = 1'b1;
    #1;
    check("miso_in_rst", bus.MISO, 1'b0);
    check("int_in_rst", bus.INT, 1'b0);
    bus.SS_n = 1'b1; bus.MOSI = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_int1 = 8'h00; m_ctrl2 = 8'h00; m_yaw = 16'h0000; m_int = 1'b0;
    repeat (4) @(negedge clk);
    spi_read(7'h0D, "rd_int1_post_rst", ib);
    spi_read(7'h11, "rd_ctrl2_post_rst", ib);
    spi_read(7'h27, "rd_h_post_rst", ib);
    spi_read(7'h0F, "rd_whoami_post_rst", ib);
    check("int_post_rst", bus.INT, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
